// File: rtl/router_read_sched.sv
// Round-robin packet reader over three byte FIFOs. It keeps at most one read in
// flight, registers the output byte, and aborts a packet whose FIFO starves.
module router_read_sched #(
    parameter int MAX_WAIT = 30
) (
    input  logic       clk1,
    input  logic       reset,
    input  logic [2:0] fifo_empty,
    input  logic [7:0] fifo_dout_0,
    input  logic [7:0] fifo_dout_1,
    input  logic [7:0] fifo_dout_2,
    input  logic       pkt_ready_i,
    output logic [2:0] rd_en,
    output logic [7:0] pkt_out,
    output logic       pkt_valid_o,
    output logic       sop_o,
    output logic       eop_o,
    output logic [2:0] grant,
    output logic       busy,
    output logic       err
);

    localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_BODY = 2'd2
    } state_e;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        logic [1:0] res;
        if (idx == 2'd2) begin
            res = 2'd0;
        end else begin
            res = idx + 2'd1;
        end
        return res;
    endfunction

    // Search starts one past the previous owner so every FIFO gets a turn.
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] empty);
        logic [1:0] c0;
        logic [1:0] c1;
        logic [1:0] c2;
        logic [1:0] res;
        c0 = next_idx(last);
        c1 = next_idx(c0);
        c2 = next_idx(c1);
        if (!empty[c0]) begin
            res = c0;
        end else if (!empty[c1]) begin
            res = c1;
        end else begin
            res = c2;
        end
        return res;
    endfunction

    function automatic logic [2:0] to_onehot(input logic [1:0] idx);
        logic [2:0] res;
        case (idx)
            2'd0:    res = 3'b001;
            2'd1:    res = 3'b010;
            2'd2:    res = 3'b100;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    state_e          state_q,      state_d;
    logic [1:0]      gidx_q,       gidx_d;
    logic [2:0]      grant_q,      grant_d;
    logic [1:0]      last_q,       last_d;
    logic            pend_q,       pend_d;
    logic [1:0]      pend_idx_q,   pend_idx_d;
    logic            pend_sop_q,   pend_sop_d;
    logic            pend_eop_q,   pend_eop_d;
    logic [6:0]      bytes_left_q, bytes_left_d;
    logic [CW-1:0]   wait_q,       wait_d;
    logic [7:0]      pkt_out_q,    pkt_out_d;
    logic            pkt_valid_q,  pkt_valid_d;
    logic            sop_q,        sop_d;
    logic            eop_q,        eop_d;
    logic            err_q,        err_d;

    logic            free_s;
    logic            starved_s;
    logic            can_read_s;
    logic [1:0]      pick_s;
    logic            issue_s;
    logic [1:0]      issue_idx_s;
    logic            hdr_done_s;
    logic            last_rd_s;
    logic            timeout_s;
    logic [7:0]      ret_byte_s;
    logic [2:0]      rd_en_s;

    assign free_s     = !pkt_valid_q || pkt_ready_i;
    assign starved_s  = !pend_q && fifo_empty[gidx_q];
    assign can_read_s = !pend_q && free_s && !fifo_empty[gidx_q];
    assign pick_s     = rr_pick(last_q, fifo_empty);

    // Select the byte returning from the FIFO read issued last cycle.
    always_comb begin
        case (pend_idx_q)
            2'd0:    ret_byte_s = fifo_dout_0;
            2'd1:    ret_byte_s = fifo_dout_1;
            2'd2:    ret_byte_s = fifo_dout_2;
            default: ret_byte_s = 8'h00;
        endcase
    end

    // State register and all datapath flops.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            gidx_q       <= 2'd0;
            grant_q      <= 3'b000;
            last_q       <= 2'd2;
            pend_q       <= 1'b0;
            pend_idx_q   <= 2'd0;
            pend_sop_q   <= 1'b0;
            pend_eop_q   <= 1'b0;
            bytes_left_q <= 7'd0;
            wait_q       <= '0;
            pkt_out_q    <= 8'h00;
            pkt_valid_q  <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            gidx_q       <= gidx_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            pend_q       <= pend_d;
            pend_idx_q   <= pend_idx_d;
            pend_sop_q   <= pend_sop_d;
            pend_eop_q   <= pend_eop_d;
            bytes_left_q <= bytes_left_d;
            wait_q       <= wait_d;
            pkt_out_q    <= pkt_out_d;
            pkt_valid_q  <= pkt_valid_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
            err_q        <= err_d;
        end
    end

    // Next-state logic; also decides whether a read issues this cycle.
    always_comb begin
        state_d     = state_q;
        issue_s     = 1'b0;
        issue_idx_s = gidx_q;
        hdr_done_s  = 1'b0;
        last_rd_s   = 1'b0;
        timeout_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fifo_empty != 3'b111) begin
                    state_d     = S_HDR;
                    issue_idx_s = pick_s;
                    issue_s     = !pend_q && free_s;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HDR: begin
                // With a read pending in HDR, the returning byte is the header.
                if (pend_q) begin
                    hdr_done_s = 1'b1;
                    state_d    = S_BODY;
                end else if (can_read_s) begin
                    issue_s = 1'b1;
                end else if (starved_s && (wait_q == WAIT_LAST)) begin
                    timeout_s = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_HDR;
                end
            end
            S_BODY: begin
                if (can_read_s) begin
                    issue_s = 1'b1;
                    if (bytes_left_q == 7'd1) begin
                        last_rd_s = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        state_d = S_BODY;
                    end
                end else if (starved_s && (wait_q == WAIT_LAST)) begin
                    timeout_s = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_BODY;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output and datapath next values driven by the decisions above.
    always_comb begin
        rd_en_s      = 3'b000;
        gidx_d       = gidx_q;
        grant_d      = grant_q;
        last_d       = last_q;
        pend_d       = issue_s;
        pend_idx_d   = issue_idx_s;
        pend_sop_d   = issue_s && (state_q != S_BODY);
        pend_eop_d   = last_rd_s;
        bytes_left_d = bytes_left_q;
        wait_d       = wait_q;
        pkt_out_d    = pkt_out_q;
        pkt_valid_d  = pkt_valid_q;
        sop_d        = sop_q;
        eop_d        = eop_q;
        err_d        = timeout_s;

        if (issue_s && !reset) begin
            rd_en_s = to_onehot(issue_idx_s);
        end else begin
            rd_en_s = 3'b000;
        end

        if ((state_q == S_IDLE) && (state_d == S_HDR)) begin
            gidx_d  = pick_s;
            grant_d = to_onehot(pick_s);
        end else if (last_rd_s || timeout_s) begin
            grant_d = 3'b000;
            last_d  = gidx_q;
        end else begin
            grant_d = grant_q;
        end

        if (hdr_done_s) begin
            bytes_left_d = {1'b0, ret_byte_s[7:2]} + 7'd1;
        end else if (issue_s && (state_q == S_BODY)) begin
            bytes_left_d = bytes_left_q - 7'd1;
        end else begin
            bytes_left_d = bytes_left_q;
        end

        // Only true starvation counts; back-pressure stalls leave it alone.
        if (issue_s || (state_d != state_q)) begin
            wait_d = '0;
        end else if (starved_s && (state_q != S_IDLE)) begin
            wait_d = wait_q + CW'(1);
        end else begin
            wait_d = wait_q;
        end

        if (pend_q) begin
            pkt_out_d   = ret_byte_s;
            pkt_valid_d = 1'b1;
            sop_d       = pend_sop_q;
            eop_d       = pend_eop_q;
        end else if (pkt_valid_q && pkt_ready_i) begin
            pkt_valid_d = 1'b0;
            sop_d       = 1'b0;
            eop_d       = 1'b0;
        end else begin
            pkt_valid_d = pkt_valid_q;
        end
    end

    assign rd_en       = rd_en_s;
    assign pkt_out     = pkt_out_q;
    assign pkt_valid_o = pkt_valid_q;
    assign sop_o       = sop_q;
    assign eop_o       = eop_q;
    assign grant       = grant_q;
    assign busy        = (state_q != S_IDLE);
    assign err         = err_q;

endmodule

// File: tb/tb_router_read_sched.sv
// Directed bench for router_read_sched: behavioural FIFOs feed the scheduler and
// accepted output bytes are logged as {sop, eop, byte} for comparison.
module tb_router_read_sched;

    logic       clk1 = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] fifo_empty;
    logic [7:0] dout [0:2] = '{8'h00, 8'h00, 8'h00};
    logic       pkt_ready_i = 1'b1;
    logic [2:0] rd_en;
    logic [7:0] pkt_out;
    logic       pkt_valid_o;
    logic       sop_o;
    logic       eop_o;
    logic [2:0] grant;
    logic       busy;
    logic       err;

    logic [7:0] mem [0:2][0:255];
    int         rp [0:2] = '{0, 0, 0};
    int         wp [0:2] = '{0, 0, 0};

    int         n_run = 0;
    int         n_fail = 0;
    logic [9:0] log_q [$];
    int         err_seen = 0;
    logic       busy_at_err = 1'b1;
    logic [2:0] grant_seen = 3'b000;
    logic [2:0] prev_rd = 3'b000;

    router_read_sched #(.MAX_WAIT(30)) dut (
        .clk1        (clk1),
        .reset       (reset),
        .fifo_empty  (fifo_empty),
        .fifo_dout_0 (dout[0]),
        .fifo_dout_1 (dout[1]),
        .fifo_dout_2 (dout[2]),
        .pkt_ready_i (pkt_ready_i),
        .rd_en       (rd_en),
        .pkt_out     (pkt_out),
        .pkt_valid_o (pkt_valid_o),
        .sop_o       (sop_o),
        .eop_o       (eop_o),
        .grant       (grant),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk1 = ~clk1;

    assign fifo_empty = {rp[2] == wp[2], rp[1] == wp[1], rp[0] == wp[0]};

    // FIFO read port: data appears the cycle after the strobe.
    always @(posedge clk1) begin
        for (int i = 0; i < 3; i++) begin
            if (rd_en[i]) begin
                dout[i] <= mem[i][rp[i]];
                rp[i]   <= rp[i] + 1;
            end
        end
    end

    task automatic push(input int f, input logic [7:0] b);
        mem[f][wp[f]] = b;
        wp[f] = wp[f] + 1;
    endtask

    // One clock: sample at negedge, check read-strobe invariants, log accepted bytes.
    task automatic step();
        @(negedge clk1);
        n_run++;
        if ((rd_en & (rd_en - 3'd1)) != 3'd0) begin
            n_fail++;
            $display("FAIL rd_en_onehot: got %b, required at most one bit", rd_en);
        end
        n_run++;
        if ((rd_en & fifo_empty) != 3'd0) begin
            n_fail++;
            $display("FAIL rd_en_empty: rd_en %b with fifo_empty %b", rd_en, fifo_empty);
        end
        n_run++;
        if ((rd_en != 3'd0) && (prev_rd != 3'd0)) begin
            n_fail++;
            $display("FAIL rd_en_pending: rd_en %b while read %b pending", rd_en, prev_rd);
        end
        n_run++;
        if ((grant != 3'd0) && ((rd_en & ~grant) != 3'd0)) begin
            n_fail++;
            $display("FAIL rd_en_grant: rd_en %b outside grant %b", rd_en, grant);
        end
        if (pkt_valid_o && pkt_ready_i) log_q.push_back({sop_o, eop_o, pkt_out});
        if (err) begin
            err_seen++;
            busy_at_err = busy;
        end
        if (grant != 3'd0) grant_seen = grant_seen | grant;
        prev_rd = rd_en;
        @(posedge clk1);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        n_run++;
        if ({rd_en, grant} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_rd_grant: got rd_en %b grant %b, required 000 000", rd_en, grant);
        end
        n_run++;
        if (pkt_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_pkt_out: got %h, required 00", pkt_out);
        end
        n_run++;
        if ({pkt_valid_o, sop_o, eop_o, busy, err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got valid/sop/eop/busy/err %b, required 00000",
                     {pkt_valid_o, sop_o, eop_o, busy, err});
        end
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_packet();
        logic [9:0] exp [0:4];
        logic [9:0] got;
        int base;
        exp = '{10'h20C, 10'h031, 10'h032, 10'h033, 10'h15A};
        base = log_q.size();
        grant_seen = 3'b000;
        push(0, 8'h0C); push(0, 8'h31); push(0, 8'h32); push(0, 8'h33); push(0, 8'h5A);
        for (int c = 0; c < 40; c++) begin
            step();
            if ((log_q.size() - base >= 5) && !busy) break;
        end
        n_run++;
        if (log_q.size() - base != 5) begin
            n_fail++;
            $display("FAIL single_count: got %0d bytes, required 5", log_q.size() - base);
        end
        for (int i = 0; i < 5; i++) begin
            got = (base + i < log_q.size()) ? log_q[base + i] : 10'h3FF;
            n_run++;
            if (got !== exp[i]) begin
                n_fail++;
                $display("FAIL single_byte%0d: got %h, required %h", i, got, exp[i]);
            end
        end
        n_run++;
        if (grant_seen !== 3'b001) begin
            n_fail++;
            $display("FAIL single_grant: got %b, required 001", grant_seen);
        end
        n_run++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_round_robin();
        logic [9:0] exp [0:9];
        logic [9:0] got;
        int base;
        exp = '{10'h200, 10'h1A0, 10'h200, 10'h1A1, 10'h200, 10'h1A2,
                10'h200, 10'h1B0, 10'h200, 10'h1B1};
        apply_reset();
        base = log_q.size();
        push(0, 8'h00); push(0, 8'hA0);
        push(1, 8'h00); push(1, 8'hA1);
        push(2, 8'h00); push(2, 8'hA2);
        for (int c = 0; c < 60; c++) begin
            step();
            if ((log_q.size() - base >= 6) && !busy) break;
        end
        push(0, 8'h00); push(0, 8'hB0);
        push(1, 8'h00); push(1, 8'hB1);
        for (int c = 0; c < 60; c++) begin
            step();
            if ((log_q.size() - base >= 10) && !busy) break;
        end
        n_run++;
        if (log_q.size() - base != 10) begin
            n_fail++;
            $display("FAIL rr_count: got %0d bytes, required 10", log_q.size() - base);
        end
        for (int i = 0; i < 10; i++) begin
            got = (base + i < log_q.size()) ? log_q[base + i] : 10'h3FF;
            n_run++;
            if (got !== exp[i]) begin
                n_fail++;
                $display("FAIL rr_byte%0d: got %h, required %h", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [9:0] exp [0:4];
        logic [9:0] got;
        logic [7:0] held;
        int base;
        int err0;
        exp = '{10'h20C, 10'h011, 10'h022, 10'h033, 10'h1C5};
        base = log_q.size();
        pkt_ready_i = 1'b1;
        push(0, 8'h0C); push(0, 8'h11); push(0, 8'h22); push(0, 8'h33); push(0, 8'hC5);
        for (int c = 0; c < 30; c++) begin
            step();
            if (log_q.size() - base >= 2) break;
        end
        pkt_ready_i = 1'b0;
        err0 = err_seen;
        step();
        step();
        held = pkt_out;
        for (int c = 0; c < 10; c++) begin
            n_run++;
            if ((pkt_valid_o !== 1'b1) || (pkt_out !== held) || (rd_en !== 3'b000)) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got valid %b out %h rd_en %b, required 1 %h 000",
                         c, pkt_valid_o, pkt_out, rd_en, held);
            end
            step();
        end
        n_run++;
        if (err_seen != err0) begin
            n_fail++;
            $display("FAIL stall_err: got %0d err pulses, required 0", err_seen - err0);
        end
        pkt_ready_i = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            if ((log_q.size() - base >= 5) && !busy) break;
        end
        n_run++;
        if (log_q.size() - base != 5) begin
            n_fail++;
            $display("FAIL stall_count: got %0d bytes, required 5", log_q.size() - base);
        end
        for (int i = 0; i < 5; i++) begin
            got = (base + i < log_q.size()) ? log_q[base + i] : 10'h3FF;
            n_run++;
            if (got !== exp[i]) begin
                n_fail++;
                $display("FAIL stall_byte%0d: got %h, required %h", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_timeout();
        logic [9:0] exp [0:3];
        logic [9:0] got;
        int base;
        int err0;
        exp = '{10'h214, 10'h055, 10'h200, 10'h1C2};
        base = log_q.size();
        err0 = err_seen;
        busy_at_err = 1'b1;
        push(1, 8'h14); push(1, 8'h55);
        push(2, 8'h00); push(2, 8'hC2);
        for (int c = 0; c < 100; c++) begin
            step();
            if ((log_q.size() - base >= 4) && !busy) break;
        end
        for (int c = 0; c < 5; c++) step();
        n_run++;
        if (err_seen - err0 != 1) begin
            n_fail++;
            $display("FAIL timeout_err: got %0d err pulses, required 1", err_seen - err0);
        end
        n_run++;
        if (busy_at_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_idle: busy %b with err, required 0", busy_at_err);
        end
        n_run++;
        if (log_q.size() - base != 4) begin
            n_fail++;
            $display("FAIL timeout_count: got %0d bytes, required 4", log_q.size() - base);
        end
        for (int i = 0; i < 4; i++) begin
            got = (base + i < log_q.size()) ? log_q[base + i] : 10'h3FF;
            n_run++;
            if (got !== exp[i]) begin
                n_fail++;
                $display("FAIL timeout_byte%0d: got %h, required %h", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [9:0] exp [0:1];
        logic [9:0] got;
        int base;
        exp = '{10'h200, 10'h1D0};
        base = log_q.size();
        push(2, 8'h10); push(2, 8'h41); push(2, 8'h42); push(2, 8'h43); push(2, 8'h44);
        push(2, 8'hE2);
        for (int c = 0; c < 30; c++) begin
            step();
            if (log_q.size() - base >= 2) break;
        end
        push(0, 8'h00); push(0, 8'hD0);
        step();
        n_run++;
        if (grant !== 3'b100) begin
            n_fail++;
            $display("FAIL midrst_grant_before: got %b, required 100", grant);
        end
        reset = 1'b1;
        #1;
        n_run++;
        if ({rd_en, grant, pkt_out} !== 14'h0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got rd_en %b grant %b out %h, required 000 000 00",
                     rd_en, grant, pkt_out);
        end
        n_run++;
        if ({pkt_valid_o, sop_o, eop_o, busy, err} !== 5'b0) begin
            n_fail++;
            $display("FAIL midrst_flags: got %b, required 00000",
                     {pkt_valid_o, sop_o, eop_o, busy, err});
        end
        wp[2] = rp[2];
        step();
        step();
        reset = 1'b0;
        base = log_q.size();
        grant_seen = 3'b000;
        for (int c = 0; c < 30; c++) begin
            step();
            if ((log_q.size() - base >= 2) && !busy) break;
        end
        for (int c = 0; c < 5; c++) step();
        n_run++;
        if (log_q.size() - base != 2) begin
            n_fail++;
            $display("FAIL midrst_count: got %0d bytes, required 2", log_q.size() - base);
        end
        for (int i = 0; i < 2; i++) begin
            got = (base + i < log_q.size()) ? log_q[base + i] : 10'h3FF;
            n_run++;
            if (got !== exp[i]) begin
                n_fail++;
                $display("FAIL midrst_byte%0d: got %h, required %h", i, got, exp[i]);
            end
        end
        n_run++;
        if (grant_seen !== 3'b001) begin
            n_fail++;
            $display("FAIL midrst_first_grant: got %b, required 001", grant_seen);
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/router_read_sched.md
ROUTER_READ_SCHED -- requirements
Module: router_read_sched

Interface
REQ-001 Parameter MAX_WAIT, default 30, meaning: idle cycles tolerated mid-packet on the granted FIFO before abort.
REQ-002 clk1  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 fifo_empty  input  3  per-FIFO empty flags, bit i = FIFO i.
REQ-005 fifo_dout_0, fifo_dout_1, fifo_dout_2  input  8 each  FIFO read data, valid the cycle after rd_en[i].
REQ-006 pkt_ready_i  input  1  downstream sink accepts pkt_out when high with pkt_valid_o.
REQ-007 rd_en  output  3  per-FIFO read strobe, at most one bit high per cycle.
REQ-008 pkt_out  output  8  registered output byte.
REQ-009 pkt_valid_o  output  1  pkt_out holds a valid byte.
REQ-010 sop_o / eop_o  output  1 each  qualify pkt_out as header byte / final byte of packet.
REQ-011 grant  output  3  one-hot index of FIFO currently owned; 0 when idle.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 err  output  1  single-cycle pulse on timeout abort.

Function
REQ-014 Packet format: header byte (bits [7:2] = payload length L, 0..63), L payload bytes, one CRC byte; total L+2 bytes.
REQ-015 States: IDLE, HDR, BODY; no other state reachable.
REQ-016 IDLE: if any fifo_empty bit low, grant the first non-empty FIFO searching round-robin from (last_grant+1) mod 3, issue rd_en for it in the same cycle, go to HDR.
REQ-017 After reset last_grant = 2, so FIFO 0 has first priority.
REQ-018 Read issue rule: rd_en[g] high only when FIFO g non-empty, no read pending, and output register free (pkt_valid_o low or pkt_ready_i high this cycle).
REQ-019 At most one read outstanding; peak throughput one byte per two cycles.
REQ-020 Returned byte loads pkt_out the cycle after rd_en, with pkt_valid_o set; pkt_out/sop_o/eop_o held stable while pkt_valid_o high and pkt_ready_i low.
REQ-021 pkt_valid_o clears on acceptance unless a new byte loads in the same cycle.
REQ-022 HDR: when header returns, sop_o set with it, bytes_left loaded with L+1, go to BODY.
REQ-023 BODY: each read issued decrements bytes_left; the byte issued at bytes_left = 1 is the CRC, returns with eop_o set; after that issue, go to IDLE with last_grant = g.
REQ-024 L = 0: BODY reads exactly one byte (CRC) with eop_o.
REQ-025 New grant from IDLE may be issued in the cycle after the CRC read issue, subject to REQ-018.
REQ-026 Timeout counter: cleared on every read issue and on state entry; increments each BODY/HDR cycle where FIFO g is empty and no read pending.
REQ-027 Counter reaching MAX_WAIT: err pulses one cycle, state to IDLE, last_grant = g, no eop_o generated; a byte already in pkt_out still delivers normally.
REQ-028 Cycles stalled by pkt_ready_i low (FIFO non-empty) do not advance the timeout counter.
REQ-029 grant changes only on IDLE exit and return to IDLE; other FIFOs' rd_en stay low during a packet regardless of their empty flags.
REQ-030 Counter width sufficient for MAX_WAIT; bytes_left 7 bits, no wrap.

Reset
REQ-031 On reset assertion, immediately: state IDLE, rd_en 0, pkt_out 8'h00, pkt_valid_o 0, sop_o 0, eop_o 0, grant 0, busy 0, err 0, last_grant 2, counters 0, pending read cleared.
REQ-032 Reset mid-packet discards the packet; read data returning after reset release from a pre-reset rd_en is ignored.

Verification
REQ-033 FIFO 0 holds header 8'h0C (L=3) + 4 bytes, sink always ready -> 5 bytes out, sop_o on first, eop_o on fifth, grant 3'b001, busy falls after CRC accepted.
REQ-034 All three FIFOs hold one L=0 packet -> served in order 0,1,2; then FIFO 0 refilled with FIFO 1 also non-empty after grant 2 -> order 0,1.
REQ-035 Sink ready low 10 cycles mid-packet -> pkt_out held constant, no rd_en, no err, packet completes intact.
REQ-036 FIFO 1 goes empty after header+1 payload of L=5 packet for MAX_WAIT cycles -> err pulse exactly once, state IDLE, no eop_o, next grant to FIFO 2 if non-empty.
REQ-037 Reset asserted during BODY of FIFO 2 -> all outputs at REQ-031 values same cycle; after release FIFO 0 served first.
REQ-038 Every cycle: rd_en at most one-hot, never high for an empty FIFO, never high with a read pending.
